// File: rtl/ps2_clk_line_ctrl.sv
// PS/2 host clock-line controller: sync + glitch filter, edge strobes,
// open-drain request-to-send inhibit / host hold, release and timeout tracking.
//
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   send_req            1-cycle pulse, start request-to-send inhibit
//   hold_inhibit        level, hold ps2_clk low while high
//   ps2_clk             open-drain PS/2 clock (driven 0 or z)
//   ps2_clk_level       filtered line level
//   ps2_clk_posedge     filtered rising-edge strobe (device edges only)
//   ps2_clk_negedge     filtered falling-edge strobe (device edges only)
//   release_pulse       line released at end of send inhibit
//   inhibit_active      this block drives ps2_clk low
//   busy                state != IDLE
//   timeout             release/device-start timeout strobe
module ps2_clk_line_ctrl #(
   parameter int CLK_FREQ_HZ      = 50000000,
   parameter int INHIBIT_US       = 100,
   parameter int FILTER_LEN       = 4,
   parameter int START_TIMEOUT_US = 15000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic send_req,
   input  logic hold_inhibit,
   inout  wire  ps2_clk,
   output logic ps2_clk_level,
   output logic ps2_clk_posedge,
   output logic ps2_clk_negedge,
   output logic release_pulse,
   output logic inhibit_active,
   output logic busy,
   output logic timeout
);

   function automatic int us2cyc(input longint us);
      longint c;
      c = (longint'(CLK_FREQ_HZ) * us) / 64'sd1000000;
      if (c < 1) c = 1;
      return int'(c);
   endfunction

   localparam int INH_CYC = us2cyc(longint'(INHIBIT_US));
   localparam int TMO_CYC = us2cyc(longint'(START_TIMEOUT_US));
   localparam int MAX_CYC = (INH_CYC > TMO_CYC) ? INH_CYC : TMO_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INH_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYC);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      HOLD,
      RELEASE,
      WAIT_DEV
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             src_tx, src_tx_d;

   logic             sync1, sync2;
   logic             lvl;
   logic [FLT_W-1:0] fcnt;
   logic             pos_q, neg_q;
   logic             masked;

   // Input path: 2-flop synchroniser and run-length glitch filter.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         lvl   <= 1'b1;
         fcnt  <= '0;
         pos_q <= 1'b0;
         neg_q <= 1'b0;
      end else begin
         sync1 <= ps2_clk;
         sync2 <= sync1;
         pos_q <= 1'b0;
         neg_q <= 1'b0;
         if (sync2 == lvl) begin
            fcnt <= '0;
         end else if (fcnt == FLT_LAST) begin
            lvl   <= sync2;
            fcnt  <= '0;
            pos_q <= sync2;
            neg_q <= ~sync2;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         src_tx <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         src_tx <= src_tx_d;
      end
   end

   always_comb begin
      state_d       = state;
      src_tx_d      = src_tx;
      release_pulse = 1'b0;
      timeout       = 1'b0;
      cnt_d         = (cnt != '0) ? cnt - 1'b1 : cnt;
      unique case (state)
         IDLE: begin
            if (hold_inhibit)  state_d = HOLD;
            else if (send_req) state_d = INHIBIT;
         end
         INHIBIT: begin
            if (hold_inhibit) begin
               state_d = HOLD;
            end else if (cnt == '0) begin
               state_d       = RELEASE;
               src_tx_d      = 1'b1;
               release_pulse = 1'b1;
            end
         end
         HOLD: begin
            if (!hold_inhibit) begin
               state_d  = RELEASE;
               src_tx_d = 1'b0;
            end
         end
         RELEASE: begin
            if (hold_inhibit) begin
               state_d = HOLD;
            end else if (lvl) begin
               state_d = src_tx ? WAIT_DEV : IDLE;
            end else if (cnt == '0) begin
               // line stuck low after release
               state_d = IDLE;
               timeout = 1'b1;
            end
         end
         WAIT_DEV: begin
            // device start edge beats a same-cycle expiry
            if (hold_inhibit) begin
               state_d = HOLD;
            end else if (neg_q) begin
               state_d = IDLE;
            end else if (cnt == '0) begin
               state_d = IDLE;
               timeout = 1'b1;
            end else if (send_req) begin
               state_d = INHIBIT;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state) begin
         unique case (1'b1)
            (state_d == INHIBIT):  cnt_d = INH_LOAD;
            (state_d == RELEASE),
            (state_d == WAIT_DEV): cnt_d = TMO_LOAD;
            default:               cnt_d = '0;
         endcase
      end
   end

   // our own drive and release edges never reach the strobes
   assign masked          = (state == INHIBIT) || (state == HOLD) ||
                            (state == RELEASE);
   assign ps2_clk_level   = lvl;
   assign ps2_clk_posedge = pos_q & ~masked;
   assign ps2_clk_negedge = neg_q & ~masked;
   assign inhibit_active  = (state == INHIBIT) || (state == HOLD);
   assign busy            = (state != IDLE);
   assign ps2_clk         = inhibit_active ? 1'b0 : 1'bz;

endmodule
